// File: rtl/fp_cond_sub_const.sv
// Conditional subtraction of a constant (2p) from a multi-digit sum, streamed LSD first.
// Digits are buffered during LOAD, then emitted one per cycle with a rippling borrow in OUT.
module fp_cond_sub_const #(
  parameter int unsigned               RADIX  = 32,
  parameter int unsigned               DIGITS = 14,
  parameter logic [RADIX*DIGITS-1:0]   CONST  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             digit_in_valid,
  input  logic [RADIX-1:0] digit_in,
  input  logic             carry_in,
  input  logic             cmp_valid,
  input  logic             sub_en,
  output logic             digit_out_valid,
  output logic [RADIX-1:0] digit_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      PTR_W    = $clog2(DIGITS + 1);
  localparam int unsigned      IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DIGITS);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_OUT
  } state_e;

  state_e           state_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             borrow_q;
  logic             sub_q;
  logic             carry_q;
  logic             cmp_seen_q;
  logic             cmp_seen_d;
  logic             load_wr;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [RADIX:0]   diff;

  logic [RADIX-1:0] digit_buf_q [DIGITS];
  logic [RADIX-1:0] const_dig   [DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_const
    assign const_dig[g] = CONST[g*RADIX +: RADIX];
  end

  assign busy = (state_q != ST_IDLE);

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    load_wr    = (state_q == ST_LOAD) && digit_in_valid && (wr_ptr_q < LAST_PTR);
    wr_ptr_d   = wr_ptr_q + PTR_W'(load_wr);
    cmp_seen_d = cmp_seen_q | ((state_q == ST_LOAD) && cmp_valid);
    wr_idx     = wr_ptr_q[IDX_W-1:0];
    rd_idx     = (rd_ptr_q < LAST_PTR) ? rd_ptr_q[IDX_W-1:0] : '0;
    // The extra top bit of the difference is the borrow-out of this digit.
    diff       = {1'b0, digit_buf_q[rd_idx]} - {1'b0, const_dig[rd_idx]}
               - {{RADIX{1'b0}}, borrow_q};
  end

  // NOTE: the digit buffer has no reset; each LOAD writes every entry before OUT reads it.
  always_ff @(posedge clk) begin
    if (load_wr) begin
      digit_buf_q[wr_idx] <= digit_in;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      borrow_q        <= 1'b0;
      sub_q           <= 1'b0;
      carry_q         <= 1'b0;
      cmp_seen_q      <= 1'b0;
      digit_out       <= '0;
      digit_out_valid <= 1'b0;
      done            <= 1'b0;
    end else begin
      digit_out       <= '0;
      digit_out_valid <= 1'b0;
      done            <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            borrow_q   <= 1'b0;
            cmp_seen_q <= 1'b0;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          wr_ptr_q   <= wr_ptr_d;
          cmp_seen_q <= cmp_seen_d;
          if (cmp_valid) begin
            sub_q   <= sub_en;
            carry_q <= carry_in;
          end
          // Look at next-state values so a last digit and cmp_valid in one cycle leave at once.
          if ((wr_ptr_d == LAST_PTR) && cmp_seen_d) begin
            state_q <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (rd_ptr_q != LAST_PTR) begin
            digit_out_valid <= 1'b1;
            rd_ptr_q        <= rd_ptr_q + ONE_PTR;
            if (sub_q) begin
              digit_out <= diff[RADIX-1:0];
              borrow_q  <= diff[RADIX];
            end else begin
              digit_out <= digit_buf_q[rd_idx];
              borrow_q  <= 1'b0;
            end
          end else begin
            done    <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A final borrow is only legal when the upstream carry absorbs it.
  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst)
    ((state_q == ST_OUT) && (rd_ptr_q == LAST_PTR) && sub_q) |-> (carry_q || !borrow_q)
  );

endmodule

// File: doc/fp_cond_sub_const.md
FP_COND_SUB_CONST -- requirements
Module: fp_cond_sub_const

Interface
REQ-001 SHALL have parameter RADIX, default 32: digit width in bits.
REQ-002 SHALL have parameter DIGITS, default 14: digits per operand.
REQ-003 SHALL have parameter CONST, RADIX*DIGITS bits, default 0: the subtrahend, i.e. 2p. Digit i is CONST[i*RADIX +: RADIX].
REQ-004 SHALL have port clk, input, 1 bit: the single clock. All state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that arms a new operation.
REQ-007 SHALL have port digit_in_valid, input, 1 bit: qualifies digit_in.
REQ-008 SHALL have port digit_in, input, RADIX bits: sum digit from the upstream adder, least-significant digit first.
REQ-009 SHALL have port carry_in, input, 1 bit: final carry of the upstream sum, sampled with cmp_valid.
REQ-010 SHALL have port cmp_valid, input, 1 bit: one-cycle pulse (upstream done) marking sub_en and carry_in as valid.
REQ-011 SHALL have port sub_en, input, 1 bit: 1 means sum >= CONST and CONST shall be subtracted.
REQ-012 SHALL have port digit_out_valid, output, 1 bit: qualifies digit_out.
REQ-013 SHALL have port digit_out, output, RADIX bits: result digit, least-significant digit first.
REQ-014 SHALL have port busy, output, 1 bit: high whenever state != IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse after the last output digit.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, OUT.
REQ-017 SHALL, in IDLE on start=1, clear wr_ptr, rd_ptr, borrow and the cmp_seen flag, then enter LOAD.
REQ-018 SHALL, in LOAD, write digit_in to buf[wr_ptr] and increment wr_ptr on each digit_in_valid while wr_ptr < DIGITS. Digits beyond DIGITS are ignored.
REQ-019 SHALL, in LOAD on cmp_valid, latch sub_en into sub_q and carry_in into carry_q, and set cmp_seen. cmp_valid may arrive before, with, or after the last digit.
REQ-020 SHALL go from LOAD to OUT in the cycle after wr_ptr==DIGITS and cmp_seen are both true. This includes the case where the last digit and cmp_valid arrive in the same cycle.
REQ-021 SHALL, in OUT, emit one digit per cycle for exactly DIGITS cycles with digit_out_valid=1:
  - sub_q=1: digit_out = buf[rd_ptr] - CONST digit rd_ptr - borrow, modulo 2^RADIX; borrow becomes the borrow-out of that digit.
  - sub_q=0: digit_out = buf[rd_ptr]; borrow stays 0.
REQ-022 SHALL register digit_out and digit_out_valid. The first valid digit appears exactly 2 cycles after the cycle that satisfied REQ-020's condition.
REQ-023 SHALL assert done for one cycle, coincident with the cycle following the last valid digit, and return to IDLE in that cycle.
REQ-024 SHALL treat the result as DIGITS digits modulo 2^(RADIX*DIGITS). carry_q absorbs the final borrow, so with sub_q=1 and carry_q=1 the final borrow is not an error.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL ignore digit_in_valid and cmp_valid in IDLE and OUT.
REQ-027 SHALL keep digit_out at 0 whenever digit_out_valid=0.

Reset
REQ-028 SHALL, when rst=0 at any time, immediately force state=IDLE and clear wr_ptr, rd_ptr, borrow, sub_q, carry_q, cmp_seen, digit_out, digit_out_valid, busy and done to 0.
REQ-029 SHALL abort any operation in progress on reset, emit no further digits, and require a new start after rst returns to 1.
REQ-030 SHALL NOT reset the buffer contents; they are overwritten by the next LOAD.

Verification
All scenarios use RADIX=4, DIGITS=4, CONST=16'h1234.
REQ-031 Sum 16'h5678, sub_en=1, carry_in=0 -> digits 4,4,4,4, then done pulse.
REQ-032 Sum 16'h5678, sub_en=0 -> digits 8,7,6,5, then done.
REQ-033 Sum 16'h2000, sub_en=1 -> digits C,C,D,0 (borrow ripple).
REQ-034 Sum digits 0,0,0,0 with carry_in=1 and sub_en=1, cmp_valid in the same cycle as the last digit -> digits C,C,D,E, first digit 2 cycles after that cycle.
REQ-035 rst=0 after the 2nd output digit -> digit_out_valid=0 and busy=0 immediately, no done. A fresh operation afterwards reproduces REQ-031 exactly.
REQ-036 start pulsed during OUT, 5 extra digit_in_valid pulses, and cmp_valid issued before any digit -> extras ignored and output identical to REQ-031.
